// File: rtl/demux_reg.sv
// Registered 1-to-2 demultiplexer with valid/ready on the input and both outputs.
// Each destination has a one-entry holding register and a wrapping transfer counter.
module demux_reg #(
  parameter int unsigned data_size = 32,
  parameter int unsigned cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [data_size-1:0] data_in,
  input  logic                 sel,
  output logic                 out1_valid,
  input  logic                 out1_ready,
  output logic [data_size-1:0] data_out1,
  output logic                 out2_valid,
  input  logic                 out2_ready,
  output logic [data_size-1:0] data_out2,
  output logic [cnt_width-1:0] count1,
  output logic [cnt_width-1:0] count2
);

  localparam logic [cnt_width-1:0] cnt_one = cnt_width'(1);

  logic accept;
  logic load1, load2;
  logic xfer1, xfer2;

  // A full register may still accept when its consumer drains it this cycle.
  always_comb begin
    in_ready = sel ? (!out2_valid || out2_ready) : (!out1_valid || out1_ready);
  end

  always_comb begin
    accept = in_valid && in_ready;
    load1  = accept && !sel;
    load2  = accept && sel;
    xfer1  = out1_valid && out1_ready;
    xfer2  = out2_valid && out2_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1_valid <= 1'b0;
      data_out1  <= '0;
      count1     <= '0;
    end else begin
      if (load1) begin
        out1_valid <= 1'b1;
        data_out1  <= data_in;
      end else if (xfer1) begin
        out1_valid <= 1'b0;
      end
      if (xfer1) count1 <= count1 + cnt_one;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out2_valid <= 1'b0;
      data_out2  <= '0;
      count2     <= '0;
    end else begin
      if (load2) begin
        out2_valid <= 1'b1;
        data_out2  <= data_in;
      end else if (xfer2) begin
        out2_valid <= 1'b0;
      end
      if (xfer2) count2 <= count2 + cnt_one;
    end
  end

endmodule

// File: tb/tb_demux_reg.sv
// Bench for demux_reg: directed scenarios plus random traffic against a slot/counter model.
// A second instance with 4-bit counters shares the stimulus to exercise counter wrap.
module tb_demux_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] data_in;
  logic        sel;
  logic        out1_ready, out2_ready;

  logic        in_ready, out1_valid, out2_valid;
  logic [31:0] data_out1, data_out2;
  logic [15:0] count1, count2;

  logic        in_ready_b, out1_valid_b, out2_valid_b;
  logic [31:0] data_out1_b, data_out2_b;
  logic [3:0]  count1_b, count2_b;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model: one slot per destination plus unbounded transfer tallies.
  bit          m_v [2];
  logic [31:0] m_d [2];
  int unsigned m_c [2];

  always #5 clk = ~clk;

  demux_reg dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .sel(sel),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .data_out1(data_out1),
    .out2_valid(out2_valid), .out2_ready(out2_ready), .data_out2(data_out2),
    .count1(count1), .count2(count2)
  );

  demux_reg #(.data_size(32), .cnt_width(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .data_in(data_in), .sel(sel),
    .out1_valid(out1_valid_b), .out1_ready(out1_ready), .data_out1(data_out1_b),
    .out2_valid(out2_valid_b), .out2_ready(out2_ready), .data_out2(data_out2_b),
    .count1(count1_b), .count2(count2_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_v[n] = 1'b0;
      m_d[n] = '0;
      m_c[n] = 0;
    end
  endtask

  task automatic drive(input bit iv, input bit s, input logic [31:0] d,
                       input bit r1, input bit r2);
    in_valid   = iv;
    sel        = s;
    data_in    = d;
    out1_ready = r1;
    out2_ready = r2;
  endtask

  function automatic bit exp_ready();
    int unsigned s = sel ? 1 : 0;
    bit r = (s == 1) ? out2_ready : out1_ready;
    return !m_v[s] || r;
  endfunction

  task automatic check_outputs();
    check("in_ready",   in_ready,   exp_ready());
    check("out1_valid", out1_valid, m_v[0]);
    check("out2_valid", out2_valid, m_v[1]);
    check("data_out1",  data_out1,  m_d[0]);
    check("data_out2",  data_out2,  m_d[1]);
    check("count1",     count1,     64'(m_c[0] % 65536));
    check("count2",     count2,     64'(m_c[1] % 65536));
    check("in_ready_b", in_ready_b, exp_ready());
    check("count1_b",   count1_b,   64'(m_c[0] % 16));
    check("count2_b",   count2_b,   64'(m_c[1] % 16));
  endtask

  // Check at the falling edge, then advance the model across the rising edge.
  task automatic cycle();
    bit          nv [2];
    logic [31:0] nd [2];
    int unsigned nc [2];
    bit          acc;
    bit          rdy [2];
    @(negedge clk);
    check_outputs();
    rdy[0] = out1_ready;
    rdy[1] = out2_ready;
    acc = in_valid && exp_ready();
    for (int n = 0; n < 2; n++) begin
      nv[n] = m_v[n];
      nd[n] = m_d[n];
      nc[n] = m_c[n];
      if (m_v[n] && rdy[n]) begin
        nc[n] = m_c[n] + 1;
        nv[n] = 1'b0;
      end
      if (acc && ((sel ? 1 : 0) == n)) begin
        nv[n] = 1'b1;
        nd[n] = data_in;
      end
    end
    @(posedge clk);
    for (int n = 0; n < 2; n++) begin
      m_v[n] = nv[n];
      m_d[n] = nd[n];
      m_c[n] = nc[n];
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, '0, 0, 0);
    model_reset();
    #1;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out1_valid", out1_valid, 1'b0);
    check("reset_count2", count2, 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();

    // Single routing to each output.
    drive(1, 0, 32'h1111_1111, 1, 1); cycle();
    drive(1, 1, 32'h2222_2222, 1, 1); cycle();
    check("route_data1", data_out1, 32'h1111_1111);
    drive(0, 0, '0, 1, 1); cycle();
    check("route_data2", data_out2, 32'h2222_2222);
    cycle();
    check("route_count1", count1, 16'd1);
    check("route_count2", count2, 16'd1);

    // Streaming into output 2.
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 32'hA000_0000 + 32'(i), 1, 1);
      cycle();
    end
    drive(0, 0, '0, 1, 1); cycle(); cycle();
    check("stream_count2", count2, 16'd9);

    // Backpressure on output 1 with bypass to output 2.
    drive(1, 0, 32'hAAAA_AAAA, 0, 1); cycle();
    drive(1, 0, 32'hBBBB_BBBB, 0, 1);
    #1 check("bp_in_ready_B", in_ready, 1'b0);
    cycle();
    drive(1, 1, 32'hCCCC_CCCC, 0, 1); cycle();
    drive(0, 0, '0, 0, 1);
    check("bp_hold_A", data_out1, 32'hAAAA_AAAA);
    check("bp_C_out2", data_out2, 32'hCCCC_CCCC);
    cycle();
    drive(0, 0, '0, 1, 1); cycle(); cycle();

    // Drain and reload of output 1 in the same cycle.
    drive(1, 0, 32'h1234_5678, 0, 1); cycle();
    drive(1, 0, 32'hDDDD_DDDD, 1, 1);
    #1 check("reload_in_ready", in_ready, 1'b1);
    cycle();
    check("reload_valid", out1_valid, 1'b1);
    check("reload_data", data_out1, 32'hDDDD_DDDD);
    drive(0, 0, '0, 1, 1); cycle();

    // Asynchronous reset with a held word.
    drive(1, 0, 32'hDEAD_BEEF, 0, 0); cycle();
    drive(0, 0, '0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_out1_valid", out1_valid, 1'b0);
    check("async_data_out1", data_out1, 32'h0);
    check("async_count1", count1, 16'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("post_reset_in_ready", in_ready, 1'b1);
    cycle();

    // 17 transfers on output 1 wrap the 4-bit counter to 1.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1, 0, 32'(i), 1, 0);
      cycle();
    end
    drive(0, 0, '0, 1, 0); cycle(); cycle();
    check("wrap_count1_b", count1_b, 4'd1);
    check("wrap_count1", count1, 16'd17);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1 rst_n = 1'b1;
      end
      cycle();
    end
    drive(0, 0, '0, 1, 1); cycle(); cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
